// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: sequencer states and requester ids.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef enum logic {CORE, HOST} req_id_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that was not granted last.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last_grant : req[HOST];
endmodule

// File: rtl/dmem_arbiter.sv
// Sequences a single-port synchronous-read data memory and shares it between
// the core load/store path and the host loader port (req/ack per port).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_ack,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = $clog2(RD_LAT) + 1;

  arb_state_t    r_state;
  req_id_t       r_last;
  req_id_t       r_gid;
  logic [CW-1:0] r_cnt;
  logic          r_core_ack, r_host_ack;
  logic          r_mem_en, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_core_rdata, r_host_rdata;
  logic          w_gnt_valid, w_gnt_id;

  rr_pick2 u_pick (
    .req       ({host_req, core_req}),
    .last_grant(r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // The granted request is latched straight into the memory-side registers,
  // which also serve as the held copy of we/addr/wdata for the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last       <= HOST;
      r_gid        <= CORE;
      r_cnt        <= '0;
      r_core_ack   <= 1'b0;
      r_host_ack   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gid       <= req_id_t'(w_gnt_id);
            r_last      <= req_id_t'(w_gnt_id);
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_gnt_id ? host_we    : core_we;
            r_mem_addr  <= w_gnt_id ? host_addr  : core_addr;
            r_mem_wdata <= w_gnt_id ? host_wdata : core_wdata;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_core_ack <= (r_gid == CORE);
            r_host_ack <= (r_gid == HOST);
            r_state    <= RESP;
          end else begin
            r_cnt   <= CW'(RD_LAT - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            if (r_gid == HOST) r_host_rdata <= mem_rdata;
            else               r_core_rdata <= mem_rdata;
            r_core_ack <= (r_gid == CORE);
            r_host_ack <= (r_gid == HOST);
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_core_ack <= 1'b0;
          r_host_ack <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_ack   = r_core_ack;
  assign host_ack   = r_host_ack;
  assign core_rdata = r_core_rdata;
  assign host_rdata = r_host_rdata;
  assign core_stall = core_req & ~r_core_ack;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, multi-cycle corner sequences on
// RD_LAT=1 and RD_LAT=3 builds, then randomized traffic against a
// transaction-level reference model.
module tb_dmem_arbiter;
  localparam int NR = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // RD_LAT=1 instance; requester inputs indexed 0=core, 1=host
  logic       rst1_n;
  logic       rq[2], wq[2];
  logic [7:0] ad[2], wd[2];
  logic       c1_ack, c1_stall, h1_ack, m1_en, m1_we, busy1;
  logic [7:0] c1_rd, h1_rd, m1_addr, m1_wd, m1_rd;

  dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(rst1_n),
    .core_req(rq[0]), .core_we(wq[0]), .core_addr(ad[0]), .core_wdata(wd[0]),
    .core_ack(c1_ack), .core_rdata(c1_rd), .core_stall(c1_stall),
    .host_req(rq[1]), .host_we(wq[1]), .host_addr(ad[1]), .host_wdata(wd[1]),
    .host_ack(h1_ack), .host_rdata(h1_rd),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wd),
    .mem_rdata(m1_rd), .busy(busy1)
  );

  // RD_LAT=3 instance; mem_rdata driven directly by the bench
  logic       rst3_n, c3_req, c3_we, h3_req, h3_we;
  logic [7:0] c3_addr, c3_wd, h3_addr, h3_wd, m3_rd;
  logic       c3_ack, c3_stall, h3_ack, m3_en, m3_we, busy3;
  logic [7:0] c3_rd, h3_rd, m3_addr, m3_wd;

  dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(rst3_n),
    .core_req(c3_req), .core_we(c3_we), .core_addr(c3_addr), .core_wdata(c3_wd),
    .core_ack(c3_ack), .core_rdata(c3_rd), .core_stall(c3_stall),
    .host_req(h3_req), .host_we(h3_we), .host_addr(h3_addr), .host_wdata(h3_wd),
    .host_ack(h3_ack), .host_rdata(h3_rd),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wd),
    .mem_rdata(m3_rd), .busy(busy3)
  );

  // Environment memory for dut1: unwritten locations read as addr^B5
  bit [7:0] emem[256];
  bit       ewr[256];
  always @(posedge clk) begin
    if (m1_en) begin
      if (m1_we) begin
        emem[m1_addr] <= m1_wd;
        ewr[m1_addr]  <= 1'b1;
      end else begin
        m1_rd <= ewr[m1_addr] ? emem[m1_addr] : (m1_addr ^ 8'hB5);
      end
    end
  end

  // Reference model state
  bit [7:0] rmem[256];
  bit       rwr[256];
  bit       rq_l[2][NR];
  logic     men_l[NR], mwe_l[NR];
  logic [7:0] maddr_l[NR], mwd_l[NR];
  int       phase[2], pst[2];

  typedef struct {
    bit       host;
    bit       we;
    bit [7:0] addr;
    bit [7:0] wd;
    bit [7:0] exp_rd;
    int       exp_lat;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single isolated transaction on dut1 starting in an IDLE cycle.
  task automatic run_one(input vec_t v);
    int got;
    int x;
    logic am, ao;
    logic [7:0] rdv;
    x = v.host ? 1 : 0;
    rq[x] = 1'b1; wq[x] = v.we; ad[x] = v.addr; wd[x] = v.wd;
    got = -1;
    #1;
    if (x == 0) chk("stall_c0", c1_stall, 1);
    for (int c = 1; c <= 10 && got < 0; c++) begin
      tick();
      am  = x ? h1_ack : c1_ack;
      ao  = x ? c1_ack : h1_ack;
      rdv = x ? h1_rd  : c1_rd;
      if (c == 1)
        chk("access_cyc1", {m1_en, m1_we, m1_addr, v.we ? m1_wd : 8'h00},
                           {1'b1, v.we, v.addr, v.we ? v.wd : 8'h00});
      chk("other_ack", ao, 0);
      if (x == 0) chk("core_stall", c1_stall, !am);
      if (am) begin
        got = c;
        if (!v.we) chk("rdata", rdv, v.exp_rd);
      end
    end
    chk("latency", got, v.exp_lat);
    tick();
    rq[x] = 1'b0;
    #1;
    chk("idle_after", {busy1, m1_en}, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, bad, L, lastg, free, n_en, nack;
    bit abort;
    bit ja[2];

    vt[0] = '{0, 0, 8'h10, 8'h00, 8'hA5, 3};
    vt[1] = '{1, 1, 8'h20, 8'h3C, 8'h00, 2};
    vt[2] = '{0, 0, 8'h20, 8'h00, 8'h3C, 3};
    vt[3] = '{1, 0, 8'hFF, 8'h00, 8'h4A, 3};
    vt[4] = '{0, 1, 8'hFF, 8'h00, 8'h00, 2};
    vt[5] = '{1, 0, 8'hFF, 8'h00, 8'h00, 3};
    vt[6] = '{0, 1, 8'h33, 8'hC3, 8'h00, 2};
    vt[7] = '{1, 0, 8'h33, 8'h00, 8'hC3, 3};

    rst1_n = 1'b0; rst3_n = 1'b0;
    rq[0] = 0; rq[1] = 0; wq[0] = 0; wq[1] = 0;
    ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0;
    c3_req = 0; c3_we = 0; c3_addr = 0; c3_wd = 0;
    h3_req = 0; h3_we = 0; h3_addr = 0; h3_wd = 0; m3_rd = 8'h00;
    #2;
    tick(); tick();
    chk("rst_state1", {busy1, c1_ack, h1_ack, m1_en, m1_we, m1_addr, m1_wd, c1_rd, h1_rd}, 0);
    chk("rst_state3", {busy3, c3_ack, h3_ack, m3_en, m3_we, m3_addr, m3_wd, c3_rd, h3_rd}, 0);
    rst1_n = 1'b1; rst3_n = 1'b1;

    foreach (vt[i]) run_one(vt[i]);

    // Both requesting from reset release: core first, then strict alternation
    rst1_n = 1'b0;
    tick();
    chk("rst_again1", {busy1, c1_ack, h1_ack, m1_en, m1_we, m1_addr, m1_wd, c1_rd, h1_rd}, 0);
    rst1_n = 1'b1;
    rq[0] = 1; wq[0] = 0; ad[0] = 8'h10;
    rq[1] = 1; wq[1] = 0; ad[1] = 8'h20;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("alt_core_ack", c1_ack, (k % 8) == 3);
      chk("alt_host_ack", h1_ack, (k % 8) == 7);
      if ((k % 8) == 3) chk("alt_core_rd", c1_rd, 8'hA5);
      if ((k % 8) == 7) chk("alt_host_rd", h1_rd, 8'h3C);
    end
    rq[0] = 0; rq[1] = 0;
    tick();

    // Host read arrives while a core write is in flight
    rq[0] = 1; wq[0] = 1; ad[0] = 8'h44; wd[0] = 8'h99;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("busy_core_ack", c1_ack, k == 2);
      chk("busy_host_ack", h1_ack, k == 6);
      if (k == 1) begin rq[1] = 1; wq[1] = 0; ad[1] = 8'h44; end
      if (k == 3) rq[0] = 0;
      if (k == 4) chk("late_host_acc", {m1_en, m1_we, m1_addr}, {1'b1, 1'b0, 8'h44});
      if (k == 6) chk("late_host_rd", h1_rd, 8'h99);
      if (k == 7) rq[1] = 0;
    end

    // RD_LAT=3: only the last WAIT cycle's mem_rdata may be captured
    c3_req = 1; c3_we = 0; c3_addr = 8'h07;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("l3_mem_en", m3_en, k == 1);
      chk("l3_ack", c3_ack, k == 5);
      if (k >= 2 && k <= 4) chk("l3_busy_wait", busy3, 1);
      if (k == 5) chk("l3_rdata", c3_rd, 8'h5A);
      m3_rd = (k == 2) ? 8'h11 : (k == 3) ? 8'h22 : (k == 4) ? 8'h5A : 8'hEE;
      if (k == 6) c3_req = 0;
    end

    // Reset pulse during WAIT drops the access; held req is redone in full
    c3_req = 1; c3_we = 0; c3_addr = 8'h09;
    tick(); tick(); tick();
    rst3_n = 1'b0;
    #1;
    chk("rst_wait", {busy3, c3_ack, m3_en, c3_stall}, 4'b0001);
    tick();
    rst3_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rr3_mem_en", m3_en, k == 1);
      chk("rr3_ack", c3_ack, k == 5);
      if (k == 5) chk("rr3_rdata", c3_rd, 8'h77);
      m3_rd = (k == 4) ? 8'h77 : 8'(8'h10 + k);
      if (k == 6) c3_req = 0;
    end

    // Randomized traffic vs transaction-level model
    rst1_n = 1'b0; rq[0] = 0; rq[1] = 0;
    tick();
    rst1_n = 1'b1;
    lastg = 1; free = 0; n_en = 0; nack = 0; abort = 0;
    phase[0] = 0; phase[1] = 0; pst[0] = 0; pst[1] = 0;
    for (int k = 0; k < NR && !abort; k++) begin
      if (k > 0) tick();
      ja[0] = 0; ja[1] = 0;
      men_l[k] = m1_en; mwe_l[k] = m1_we; maddr_l[k] = m1_addr; mwd_l[k] = m1_wd;
      if (m1_en) n_en++;
      for (int x = 0; x < 2; x++) begin
        if (x == 1 ? h1_ack : c1_ack) begin
          nack++;
          chk("excl_ack", x == 1 ? c1_ack : h1_ack, 0);
          chk("ack_pending", phase[x] == 1, 1);
          L = wq[x] ? 2 : 3;
          g = k - L;
          if (g < free) chk("grant_slot", g, free);
          else begin
            bad = 0;
            for (int c = free; c < g; c++) if (rq_l[0][c] || rq_l[1][c]) bad = 1;
            chk("no_wasted_idle", bad, 0);
            chk("req_at_grant", rq_l[x][g] && pst[x] <= g, 1);
            if (rq_l[0][g] && rq_l[1][g]) chk("rr_alternate", x != lastg, 1);
            chk("mem_access", {men_l[g+1], mwe_l[g+1], maddr_l[g+1], wq[x] ? mwd_l[g+1] : 8'h00},
                              {1'b1, wq[x], ad[x], wq[x] ? wd[x] : 8'h00});
          end
          if (wq[x]) begin
            rmem[ad[x]] = wd[x];
            rwr[ad[x]]  = 1'b1;
          end else begin
            chk("rand_rdata", x == 1 ? h1_rd : c1_rd,
                rwr[ad[x]] ? rmem[ad[x]] : (ad[x] ^ 8'hB5));
          end
          free = k + 1; lastg = x; phase[x] = 2; ja[x] = 1;
        end
      end
      for (int x = 0; x < 2; x++) begin
        if (!ja[x]) begin
          if (phase[x] == 1) begin
            if (k - pst[x] > 30) begin
              chk("req_timeout", k - pst[x], 30);
              abort = 1;
            end
          end else if ($urandom_range(0, 99) < (phase[x] == 2 ? 50 : 30)) begin
            rq[x] = 1'b1;
            wq[x] = 1'($urandom_range(0, 1));
            ad[x] = 8'h80 | 8'($urandom_range(0, 15));
            wd[x] = 8'($urandom);
            pst[x] = k; phase[x] = 1;
          end else begin
            rq[x] = 1'b0; phase[x] = 0;
          end
        end
      end
      #1;
      rq_l[0][k] = rq[0];
      rq_l[1][k] = rq[1];
      chk("rand_stall", c1_stall, rq[0] & ~c1_ack);
    end
    chk("en_vs_ack", (n_en == nack) || (n_en == nack + 1), 1);
    chk("activity", nack > 150, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
